// File: rtl/dtlb_ptw.sv
// dtlb_ptw: Sv48 page-table walker that fills the data TLB.
// One miss at a time, one outstanding PTE read, restart on TLB invalidate.
// Optional one-entry page-walk cache enabled by defining DTLB_PTW_PWC_EN.
module dtlb_ptw #(
  parameter int NPHYS = 44,
  parameter int VA_SZ = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              miss_req,
  input  logic [VA_SZ-1:12] miss_vaddr,
  input  logic [15:0]       miss_asid,
  output logic              miss_rdy,
  output logic              miss_done,
  output logic              miss_fault,
  input  logic [NPHYS-1:12] satp_ppn,
  input  logic              inval,
  output logic              mem_req,
  output logic [NPHYS-1:3]  mem_paddr,
  input  logic              mem_ack,
  input  logic [63:0]       mem_data,
  output logic              wr_entry,
  output logic [VA_SZ-1:12] wr_vaddr,
  output logic [15:0]       wr_asid,
  output logic [NPHYS-1:12] wr_paddr,
  output logic [6:0]        wr_gaduwrx,
  output logic              wr_2mB,
  output logic              wr_4mB,
  output logic              wr_1gB,
  output logic              wr_512gB
);

  typedef enum logic [1:0] {IDLE, REQ, CHECK, DONE} state_t;

  state_t            state;
  logic [VA_SZ-1:12] vaddr;
  logic [15:0]       asid;
  logic [NPHYS-1:12] ppn;
  logic [1:0]        lvl;
  logic              gsticky;
  logic              stale;
  logic [7:0]        pte_flags;
  logic [NPHYS-1:12] pte_ppn;

  // PTE flag decode
  logic pte_v, pte_r, pte_w, pte_x, pte_u, pte_g, pte_a, pte_d;
  assign {pte_d, pte_a, pte_g, pte_u, pte_x, pte_w, pte_r, pte_v} = pte_flags;

  logic [8:0] vpn_sel;
  logic       misaligned;
  logic       chk_bad;
  logic       pte_leaf;
  logic       chk_descend;
  logic       chk_fault;

  // Walk start point (root, or the cached level-0 table on a walk-cache hit)
  logic [NPHYS-1:12] start_ppn;
  logic [1:0]        start_lvl;
  logic              start_g;

  // Reserved and upper PTE bits play no part in the walk
  logic unused_pte_bits;
  assign unused_pte_bits = ^{mem_data[63:NPHYS-2], mem_data[9:8]};

  // Select the VPN slice for the current level and test superpage alignment
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    vpn_sel    = vaddr[12 +: 9];
    misaligned = 1'b0;
    case (lvl)
      2'd0: vpn_sel = vaddr[12 +: 9];
      2'd1: begin
        vpn_sel    = vaddr[21 +: 9];
        misaligned = |pte_ppn[20:12];
      end
      2'd2: begin
        vpn_sel    = vaddr[30 +: 9];
        misaligned = |pte_ppn[29:12];
      end
      default: begin
        vpn_sel    = vaddr[39 +: 9];
        misaligned = |pte_ppn[38:12];
      end
    endcase
  end

  assign mem_paddr   = {ppn, vpn_sel};
  assign chk_bad     = !pte_v || (!pte_r && pte_w) || !pte_a;
  assign pte_leaf    = pte_r || pte_x;
  assign chk_descend = !chk_bad && !pte_leaf && (lvl != 2'd0);
  assign chk_fault   = chk_bad || (!pte_leaf && (lvl == 2'd0)) || (pte_leaf && misaligned);
  assign wr_4mB      = 1'b0;

`ifdef DTLB_PTW_PWC_EN
  logic              pwc_valid;
  logic [VA_SZ-1:21] pwc_tag;
  logic [15:0]       pwc_asid;
  logic              pwc_g;
  logic [NPHYS-1:12] pwc_ppn;
  logic              pwc_hit;
  logic              pwc_fill;

  assign pwc_fill  = (state == CHECK) && !stale && chk_descend && (lvl == 2'd1);
  assign pwc_hit   = pwc_valid && (pwc_tag == miss_vaddr[VA_SZ-1:21]) &&
                     ((pwc_asid == miss_asid) || pwc_g);
  assign start_ppn = pwc_hit ? pwc_ppn : satp_ppn;
  assign start_lvl = pwc_hit ? 2'd0 : 2'd3;
  assign start_g   = pwc_hit && pwc_g;

  // Walk-cache valid bit: set on an accepted level-1 pointer, cleared by any invalidate
  always_ff @(posedge clk) begin
    if (reset || inval) begin
      pwc_valid <= 1'b0;
    end else if (pwc_fill) begin
      pwc_valid <= 1'b1;
    end
  end

  // Walk-cache payload, qualified by pwc_valid
  always_ff @(posedge clk) begin
    // NOTE: the payload has no reset; pwc_valid alone decides whether it is meaningful.
    if (pwc_fill) begin
      pwc_tag  <= vaddr[VA_SZ-1:21];
      pwc_asid <= asid;
      pwc_g    <= gsticky | pte_g;
      pwc_ppn  <= pte_ppn;
    end
  end
`else
  assign start_ppn = satp_ppn;
  assign start_lvl = 2'd3;
  assign start_g   = 1'b0;
`endif

  // Walker FSM with registered handshake and fill outputs
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register here sees pre-edge values.
    if (reset) begin
      state      <= IDLE;
      miss_rdy   <= 1'b1;
      miss_done  <= 1'b0;
      miss_fault <= 1'b0;
      mem_req    <= 1'b0;
      wr_entry   <= 1'b0;
      stale      <= 1'b0;
      vaddr      <= '0;
      asid       <= '0;
      ppn        <= '0;
      lvl        <= 2'd0;
      gsticky    <= 1'b0;
      pte_flags  <= '0;
      pte_ppn    <= '0;
      wr_vaddr   <= '0;
      wr_asid    <= '0;
      wr_paddr   <= '0;
      wr_gaduwrx <= '0;
      wr_2mB     <= 1'b0;
      wr_1gB     <= 1'b0;
      wr_512gB   <= 1'b0;
    end else begin
      wr_entry   <= 1'b0;
      miss_done  <= 1'b0;
      miss_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (miss_req) begin
            vaddr    <= miss_vaddr;
            asid     <= miss_asid;
            ppn      <= start_ppn;
            lvl      <= start_lvl;
            gsticky  <= start_g;
            stale    <= 1'b0;
            miss_rdy <= 1'b0;
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end
        REQ: begin
          if (inval) stale <= 1'b1;
          if (mem_ack) begin
            pte_flags <= mem_data[7:0];
            pte_ppn   <= mem_data[NPHYS-3:10];
            mem_req   <= 1'b0;
            state     <= CHECK;
          end
        end
        CHECK: begin
          if (stale) begin
            // Result may predate an invalidate: throw it away and walk again from the root.
            stale   <= 1'b0;
            ppn     <= satp_ppn;
            lvl     <= 2'd3;
            gsticky <= 1'b0;
            mem_req <= 1'b1;
            state   <= REQ;
          end else if (chk_descend) begin
            if (inval) stale <= 1'b1;
            ppn     <= pte_ppn;
            gsticky <= gsticky | pte_g;
            lvl     <= lvl - 2'd1;
            mem_req <= 1'b1;
            state   <= REQ;
          end else begin
            // Outcome is fixed here; an invalidate now is ordered after the fill by the TLB.
            miss_done  <= 1'b1;
            miss_fault <= chk_fault;
            wr_entry   <= !chk_fault;
            if (!chk_fault) begin
              wr_vaddr   <= vaddr;
              wr_asid    <= asid;
              wr_paddr   <= pte_ppn;
              wr_gaduwrx <= {pte_g | gsticky, pte_a, pte_d, pte_u, pte_w, pte_r, pte_x};
              wr_512gB   <= (lvl == 2'd3);
              wr_1gB     <= (lvl == 2'd2);
              wr_2mB     <= (lvl == 2'd1);
            end
            state <= DONE;
          end
        end
        DONE: begin
          miss_rdy <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          miss_rdy <= 1'b1;
          mem_req  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dtlb_ptw.sv
// tb_dtlb_ptw: directed, table-driven bench for the dtlb_ptw page-table walker.
// Define DTLB_PTW_PWC_EN to also exercise the page-walk cache.
module tb_dtlb_ptw;

  localparam int NPHYS = 44;
  localparam int VA_SZ = 48;

  typedef struct {
    string       name;
    logic [35:0] va;
    logic [31:0] root;
    bit          fault;
    logic [31:0] pa;
    logic [6:0]  perm;
    logic [3:0]  size;   // {512g, 1g, 2m, 4m}
    int          reads;
    int          cycles;
  } vec_t;

  typedef struct {
    bit          done;
    bit          fault;
    bit          entry;
    logic [31:0] pa;
    logic [6:0]  perm;
    logic [3:0]  size;
    logic [35:0] va;
    logic [15:0] asid;
    int          cycles;
    int          reads;
  } res_t;

  logic              clk;
  logic              reset;
  logic              miss_req;
  logic [VA_SZ-1:12] miss_vaddr;
  logic [15:0]       miss_asid;
  logic              miss_rdy;
  logic              miss_done;
  logic              miss_fault;
  logic [NPHYS-1:12] satp_ppn;
  logic              inval;
  logic              mem_req;
  logic [NPHYS-1:3]  mem_paddr;
  logic              mem_ack;
  logic [63:0]       mem_data;
  logic              wr_entry;
  logic [VA_SZ-1:12] wr_vaddr;
  logic [15:0]       wr_asid;
  logic [NPHYS-1:12] wr_paddr;
  logic [6:0]        wr_gaduwrx;
  logic              wr_2mB;
  logic              wr_4mB;
  logic              wr_1gB;
  logic              wr_512gB;

  dtlb_ptw #(.NPHYS(NPHYS), .VA_SZ(VA_SZ)) dut (
    .clk       (clk),
    .reset     (reset),
    .miss_req  (miss_req),
    .miss_vaddr(miss_vaddr),
    .miss_asid (miss_asid),
    .miss_rdy  (miss_rdy),
    .miss_done (miss_done),
    .miss_fault(miss_fault),
    .satp_ppn  (satp_ppn),
    .inval     (inval),
    .mem_req   (mem_req),
    .mem_paddr (mem_paddr),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .wr_entry  (wr_entry),
    .wr_vaddr  (wr_vaddr),
    .wr_asid   (wr_asid),
    .wr_paddr  (wr_paddr),
    .wr_gaduwrx(wr_gaduwrx),
    .wr_2mB    (wr_2mB),
    .wr_4mB    (wr_4mB),
    .wr_1gB    (wr_1gB),
    .wr_512gB  (wr_512gB)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Memory model state
  logic [63:0]      mem [logic [NPHYS-1:3]];
  bit               auto_mem;
  int               mem_lat;
  int               rd_cnt;
  logic [NPHYS-1:3] rd_addr[$];
  int               wr_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] nl(input logic [31:0] p);
    return ({32'h0, p} << 10) | 64'h41;   // pointer PTE: V=1, A=1
  endfunction

  // Memory responder: acknowledges mem_req after mem_lat idle cycles, driven on negedge
  initial begin : responder
    int wait_cnt;
    wait_cnt = 0;
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (auto_mem) begin
        if (mem_ack) begin
          mem_ack  = 1'b0;
          wait_cnt = 0;
        end else if (mem_req) begin
          if (wait_cnt >= mem_lat) begin
            mem_ack  = 1'b1;
            mem_data = mem.exists(mem_paddr) ? mem[mem_paddr] : 64'h0;
            rd_addr.push_back(mem_paddr);
            rd_cnt++;
          end else begin
            wait_cnt++;
          end
        end
      end
    end
  end

  // Fill strobe counter
  initial begin
    forever begin
      @(negedge clk);
      if (wr_entry) wr_cnt++;
    end
  end

  // Present one miss (caller is at a negedge) and wait, bounded, for miss_done
  task automatic run_walk(input logic [35:0] va, input logic [31:0] root, output res_t r);
    int n;
    n = 0;
    while (!miss_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    rd_cnt = 0;
    rd_addr.delete();
    miss_vaddr = va;
    miss_asid  = 16'h0005;
    satp_ppn   = root;
    miss_req   = 1'b1;
    @(negedge clk);
    miss_req = 1'b0;
    r.cycles = 1;
    while (!miss_done && r.cycles < 200) begin
      @(negedge clk);
      r.cycles++;
    end
    r.done  = miss_done;
    r.fault = miss_fault;
    r.entry = wr_entry;
    r.pa    = wr_paddr;
    r.perm  = wr_gaduwrx;
    r.size  = {wr_512gB, wr_1gB, wr_2mB, wr_4mB};
    r.va    = wr_vaddr;
    r.asid  = wr_asid;
    r.reads = rd_cnt;
    @(negedge clk);
  endtask

  task automatic pulse_inval();
    @(negedge clk);
    inval = 1'b1;
    @(negedge clk);
    inval = 1'b0;
    check("inval_idle_rdy", miss_rdy, 1);
  endtask

  vec_t vecs[8];

  initial begin
    res_t r;
    int   wr0;

    reset      = 1'b1;
    miss_req   = 1'b0;
    miss_vaddr = '0;
    miss_asid  = '0;
    satp_ppn   = '0;
    inval      = 1'b0;
    auto_mem   = 1'b1;
    mem_lat    = 1;
    rd_cnt     = 0;

    // Page tables: root 0x100
    mem[41'h20000] = nl(32'h101);                 // L3 vpn3=0
    mem[41'h20201] = nl(32'h102);                 // L2 vpn2=1
    mem[41'h20401] = nl(32'h103);                 // L1 vpn1=1
    mem[41'h20601] = 64'h0000_0000_1234_50CF;     // L0 vpn0=1: 4K leaf
    mem[41'h20602] = 64'h0000_0000_1234_54CF;     // L0 vpn0=2: 4K leaf PPN 0x48D15
    mem[41'h20202] = 64'h0000_0000_1000_00CF;     // 1G leaf PPN 0x40000
    mem[41'h20203] = 64'h0000_0000_1000_04CF;     // 1G leaf PPN 0x40001 (misaligned)
    mem[41'h20204] = 64'h0000_0000_1000_00CD;     // W=1 R=0
    mem[41'h20205] = nl(32'h110);
    mem[41'h22000] = nl(32'h111);
    mem[41'h22200] = nl(32'h112);                 // pointer at level 0
    mem[41'h20206] = 64'h0000_0000_1000_008F;     // A=0
    mem[41'h20207] = 64'h0000_0000_0004_8061;     // pointer to 0x120 with G=1
    mem[41'h24000] = 64'h0000_0000_1008_00DB;     // 2M leaf PPN 0x40200, U, no W
    mem[41'h40000] = 64'h0;                       // root 0x200: invalid PTE

    repeat (3) @(negedge clk);
    check("reset_miss_rdy",   miss_rdy,   1);
    check("reset_mem_req",    mem_req,    0);
    check("reset_wr_entry",   wr_entry,   0);
    check("reset_miss_done",  miss_done,  0);
    check("reset_miss_fault", miss_fault, 0);
    check("reset_mem_paddr",  mem_paddr,  0);
    check("reset_wr_paddr",   wr_paddr,   0);
    check("reset_wr_perm",    wr_gaduwrx, 0);
    reset = 1'b0;
    @(negedge clk);

    vecs[0] = '{"4k",          36'h40201,  32'h100, 1'b0, 32'h48D14, 7'b0110111, 4'b0000, 4, 13};
    vecs[1] = '{"1g",          36'h80000,  32'h100, 1'b0, 32'h40000, 7'b0110111, 4'b0100, 2, 7};
    vecs[2] = '{"1g_misalign", 36'hC0000,  32'h100, 1'b1, 32'h0,     7'b0,       4'b0000, 2, 7};
    vecs[3] = '{"v0_l3",       36'h00000,  32'h200, 1'b1, 32'h0,     7'b0,       4'b0000, 1, 4};
    vecs[4] = '{"w_no_r",      36'h100000, 32'h100, 1'b1, 32'h0,     7'b0,       4'b0000, 2, 7};
    vecs[5] = '{"ptr_at_l0",   36'h140000, 32'h100, 1'b1, 32'h0,     7'b0,       4'b0000, 4, 13};
    vecs[6] = '{"a0_leaf",     36'h180000, 32'h100, 1'b1, 32'h0,     7'b0,       4'b0000, 2, 7};
    vecs[7] = '{"2m_gsticky",  36'h1C0000, 32'h100, 1'b0, 32'h40200, 7'b1111011, 4'b0010, 3, 10};

    for (int i = 0; i < 8; i++) begin
      wr0 = wr_cnt;
      run_walk(vecs[i].va, vecs[i].root, r);
      check($sformatf("%s_done", vecs[i].name),   r.done,   1);
      check($sformatf("%s_fault", vecs[i].name),  r.fault,  vecs[i].fault);
      check($sformatf("%s_entry", vecs[i].name),  r.entry,  !vecs[i].fault);
      check($sformatf("%s_reads", vecs[i].name),  r.reads,  vecs[i].reads);
      check($sformatf("%s_cycles", vecs[i].name), r.cycles, vecs[i].cycles);
      check($sformatf("%s_fills", vecs[i].name),  wr_cnt - wr0, vecs[i].fault ? 0 : 1);
      if (!vecs[i].fault) begin
        check($sformatf("%s_paddr", vecs[i].name), r.pa,   vecs[i].pa);
        check($sformatf("%s_perm", vecs[i].name),  r.perm, vecs[i].perm);
        check($sformatf("%s_size", vecs[i].name),  r.size, vecs[i].size);
        check($sformatf("%s_vaddr", vecs[i].name), r.va,   vecs[i].va);
        check($sformatf("%s_asid", vecs[i].name),  r.asid, 16'h0005);
      end
      if (i == 0) begin
        check("4k_addr0", rd_addr[0], 41'h20000);
        check("4k_addr1", rd_addr[1], 41'h20201);
        check("4k_addr2", rd_addr[2], 41'h20401);
        check("4k_addr3", rd_addr[3], 41'h20601);
      end
    end

    // Invalidate while the third read is outstanding: the walk must restart from the root
    mem_lat = 3;
    pulse_inval();
    @(negedge clk);
    fork
      run_walk(36'h40201, 32'h100, r);
      begin : pulser
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 200) begin
          @(posedge clk);
          #1;
          n++;
          if (rd_cnt == 2 && mem_req && !mem_ack) hit = 1'b1;
        end
        check("inval_window_found", hit, 1);
        if (hit) begin
          inval = 1'b1;
          @(posedge clk);
          #1;
          inval = 1'b0;
        end
      end
    join
    check("inval_done",    r.done,  1);
    check("inval_fault",   r.fault, 0);
    check("inval_entry",   r.entry, 1);
    check("inval_reads",   r.reads, 7);
    check("inval_restart", rd_addr[3], 41'h20000);
    check("inval_last",    rd_addr[6], 41'h20601);
    check("inval_paddr",   r.pa, 32'h48D14);
    mem_lat = 1;

    // Reset during REQ, with a late acknowledge the following cycle
    @(negedge clk);
    auto_mem   = 1'b0;
    wr0        = wr_cnt;
    miss_vaddr = 36'h40201;
    satp_ppn   = 32'h100;
    miss_req   = 1'b1;
    @(negedge clk);
    miss_req = 1'b0;
    check("rst_walk_mem_req", mem_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    mem_ack  = 1'b1;
    mem_data = 64'h0000_0000_1234_50CF;
    check("rst_mem_req_dropped", mem_req,  0);
    check("rst_miss_rdy",        miss_rdy, 1);
    @(negedge clk);
    mem_ack = 1'b0;
    check("rst_late_ack_mem_req", mem_req,  0);
    check("rst_late_ack_rdy",     miss_rdy, 1);
    repeat (4) @(negedge clk);
    check("rst_no_fill", wr_cnt - wr0, 0);
    check("rst_no_done", miss_done, 0);
    auto_mem = 1'b1;

`ifdef DTLB_PTW_PWC_EN
    // Page-walk cache: a neighbour 4K page reuses the cached level-0 table
    run_walk(36'h40201, 32'h100, r);
    check("pwc_first_reads", r.reads, 4);
    run_walk(36'h40202, 32'h100, r);
    check("pwc_hit_reads", r.reads, 1);
    check("pwc_hit_entry", r.entry, 1);
    check("pwc_hit_paddr", r.pa, 32'h48D15);
    check("pwc_hit_addr",  rd_addr[0], 41'h20602);
    pulse_inval();
    run_walk(36'h40202, 32'h100, r);
    check("pwc_after_inval_reads", r.reads, 4);
    check("pwc_after_inval_paddr", r.pa, 32'h48D15);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
